// File: rtl/screen_transition_fader.sv
// screen_transition_fader: sits between the game state controller's RGB output
// and the VGA DAC. A change of the 2-bit game state blanks the picture, holds
// it black for a number of frames, then fades the new screen in linearly.
// Brightness only changes at the first pixel of a frame, so there is no
// mid-frame tearing. With no transition running it is a 1-cycle registered
// pass-through.
//
// Build option: define SCREEN_FADER_HOLD_EN to include the black hold phase
// (BLACK state plus hold_cnt). Without it, a change drops straight into
// FADE_IN at level 0, so exactly one black frame precedes the fade.
module screen_transition_fader #(
  parameter int STEP        = 16,  // brightness increment per frame, 1..256
  parameter int HOLD_FRAMES = 8    // black frames before fade-in, 1..255
) (
  input  logic       VGA_Clk,
  input  logic       Reset,
  input  logic [1:0] State_in,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  input  logic       blank,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       busy,
  output logic [1:0] fsm_state
);

  if (STEP < 1 || STEP > 256 || HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_param_check
    $error("screen_transition_fader: STEP or HOLD_FRAMES out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BLACK   = 2'd1,
    FADE_IN = 2'd2
  } fade_state_t;

  localparam logic [9:0] STEP_W      = 10'(STEP);
  localparam logic [8:0] FIRST_LEVEL = (STEP >= 256) ? 9'd256 : 9'(STEP);
  localparam logic [8:0] UNITY       = 9'd256;

  fade_state_t state, state_nxt;
  logic [8:0]  level, level_nxt;   // 256 means unity gain
  logic [9:0]  sum;
  logic [1:0]  state_q;
  logic        pending;
  logic        primed;              // low only on the first clock after reset
  logic        xy0_q;
  logic        xy0, fs, chg, trig;

`ifdef SCREEN_FADER_HOLD_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  logic [7:0] hold_cnt, hold_nxt;
`endif

  // Frame-start pulse and game-state change detection. The first clock after
  // reset only loads state_q, so a state already present at reset release
  // does not start a fade.
  always_comb begin
    xy0  = (DrawX == 10'd0) && (DrawY == 10'd0);
    fs   = xy0 && !xy0_q;
    chg  = primed && (State_in != state_q);
    trig = pending || chg;
  end

  // Next-state and next-level logic; everything only moves at a frame start.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
`ifdef SCREEN_FADER_HOLD_EN
    hold_nxt  = hold_cnt;
`endif
    sum = {1'b0, level} + STEP_W;
    if (fs) begin
      case (state)
        IDLE, FADE_IN: begin
          if (trig) begin
            level_nxt = 9'd0;
`ifdef SCREEN_FADER_HOLD_EN
            state_nxt = BLACK;
            hold_nxt  = HOLD_LAST;
`else
            state_nxt = FADE_IN;
`endif
          end else if (state == FADE_IN) begin
            if (sum >= 10'd256) begin
              level_nxt = UNITY;
              state_nxt = IDLE;
            end else begin
              level_nxt = sum[8:0];
            end
          end
        end
`ifdef SCREEN_FADER_HOLD_EN
        BLACK: begin
          if (trig) begin
            hold_nxt = HOLD_LAST;
          end else if (hold_cnt == 8'd0) begin
            state_nxt = FADE_IN;
            level_nxt = FIRST_LEVEL;
          end else begin
            hold_nxt = hold_cnt - 8'd1;
          end
        end
`endif
        default: begin
          state_nxt = IDLE;
          level_nxt = UNITY;
        end
      endcase
    end
  end

  // Control registers: FSM, level, change tracking and frame-start history.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      level   <= UNITY;
      state_q <= 2'd0;
      pending <= 1'b0;
      primed  <= 1'b0;
      xy0_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      state_q <= State_in;
      pending <= fs ? 1'b0 : (pending || chg);
      primed  <= 1'b1;
      xy0_q   <= xy0;
    end
  end

`ifdef SCREEN_FADER_HOLD_EN
  // Black-hold frame counter.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) hold_cnt <= 8'd0;
    else       hold_cnt <= hold_nxt;
  end
`endif

  // Channel scale: 8-bit colour times 9-bit level, keep product bits [15:8].
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] l);
    logic [16:0] p;
    p = {9'd0, c} * {8'd0, l};
    return 8'(p >> 8);
  endfunction

  // Registered pixel output. The level for this pixel is the one that takes
  // effect on this edge, so pixel (0,0) of a frame already sees the new level.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      Red   <= 8'd0;
      Green <= 8'd0;
      Blue  <= 8'd0;
    end else if (!blank) begin
      Red   <= 8'd0;
      Green <= 8'd0;
      Blue  <= 8'd0;
    end else begin
      Red   <= scale(Red_in,   level_nxt);
      Green <= scale(Green_in, level_nxt);
      Blue  <= scale(Blue_in,  level_nxt);
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_screen_transition_fader.sv
// Directed bench for screen_transition_fader. Two instances share all inputs:
// dut_a with default STEP/HOLD_FRAMES and dut_b with STEP=100, HOLD_FRAMES=1.
// A frame-level model predicts every output cycle; a few literal values pin
// the model. Frames are shrunk to W x H pixels to keep runs short.
module tb_screen_transition_fader;
  localparam int W = 8;
  localparam int H = 4;
  localparam int STEP_A = 16;
  localparam int HOLD_A = 8;
  localparam int STEP_B = 100;
  localparam int HOLD_B = 1;
`ifdef SCREEN_FADER_HOLD_EN
  localparam int EFF_A = HOLD_A;
  localparam int EFF_B = HOLD_B;
`else
  localparam int EFF_A = 1;
  localparam int EFF_B = 1;
`endif

  logic       VGA_Clk;
  logic       Reset = 1'b1;
  logic [1:0] State_in = 2'd0;
  logic [7:0] Red_in = 8'd0, Green_in = 8'd0, Blue_in = 8'd0;
  logic       blank = 1'b1;
  logic [9:0] DrawX = 10'd5, DrawY = 10'd5;
  logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic       busy_a, busy_b;
  logic [1:0] st_a, st_b;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial VGA_Clk = 1'b0;
  always #5 VGA_Clk = ~VGA_Clk;

  screen_transition_fader #(.STEP(STEP_A), .HOLD_FRAMES(HOLD_A)) dut_a (
    .VGA_Clk(VGA_Clk), .Reset(Reset), .State_in(State_in),
    .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY),
    .Red(red_a), .Green(green_a), .Blue(blue_a), .busy(busy_a), .fsm_state(st_a));

  screen_transition_fader #(.STEP(STEP_B), .HOLD_FRAMES(HOLD_B)) dut_b (
    .VGA_Clk(VGA_Clk), .Reset(Reset), .State_in(State_in),
    .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY),
    .Red(red_b), .Green(green_b), .Blue(blue_b), .busy(busy_b), .fsm_state(st_b));

  // ---------------- frame-level model ----------------
  // Per instance: current gain, black frames still owed, busy.
  int         m_lvl[2];
  int         m_black[2];
  bit         m_busy[2];
  bit         m_pend, m_prev_xy0, m_primed;
  logic [1:0] m_prev;
  bit         mx_xy0, mx_fs, mx_chg, mx_trig;
  logic [49:0] exp_q[$];

  function automatic logic [7:0] scl(input logic [7:0] c, input int lvl, input logic bl);
    return bl ? 8'((int'(c) * lvl) / 256) : 8'd0;
  endfunction

  function automatic logic [24:0] exp_vec(input int i);
    return {m_busy[i], scl(Red_in, m_lvl[i], blank), scl(Green_in, m_lvl[i], blank),
            scl(Blue_in, m_lvl[i], blank)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 256; m_black[i] = 0; m_busy[i] = 1'b0;
    end
    m_pend = 1'b0; m_prev_xy0 = 1'b0; m_primed = 1'b0; m_prev = 2'd0;
    exp_q.delete();
  endtask

  // One frame boundary: a pending change restarts the black period,
  // otherwise black frames run out first and then the gain climbs by STEP.
  task automatic model_frame(input int i, input bit trig);
    int step;
    int eff;
    step = (i == 0) ? STEP_A : STEP_B;
    eff  = (i == 0) ? EFF_A : EFF_B;
    if (trig) begin
      m_lvl[i] = 0; m_black[i] = eff - 1; m_busy[i] = 1'b1;
    end else if (m_busy[i]) begin
      if (m_black[i] > 0) m_black[i] = m_black[i] - 1;
      else begin
        m_lvl[i] = (m_lvl[i] + step > 256) ? 256 : m_lvl[i] + step;
        if (m_lvl[i] == 256) m_busy[i] = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge VGA_Clk or posedge Reset);
      if (Reset) model_reset();
      else begin
        mx_xy0  = (DrawX == 10'd0) && (DrawY == 10'd0);
        mx_fs   = mx_xy0 && !m_prev_xy0;
        mx_chg  = m_primed && (State_in != m_prev);
        mx_trig = m_pend || mx_chg;
        if (mx_fs) begin
          model_frame(0, mx_trig);
          model_frame(1, mx_trig);
        end
        exp_q.push_back({exp_vec(0), exp_vec(1)});
        m_pend     = mx_fs ? 1'b0 : (m_pend || mx_chg);
        m_prev     = State_in;
        m_prev_xy0 = mx_xy0;
        m_primed   = 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard compare of both instances for the cycle just clocked.
  task automatic sb_check();
    logic [49:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("pixel_a", {7'd0, busy_a, red_a, green_a, blue_a}, {7'd0, e[49:25]});
      check("pixel_b", {7'd0, busy_b, red_b, green_b, blue_b}, {7'd0, e[24:0]});
    end
  endtask

  // ---------------- drivers ----------------
  logic [7:0] red_val = 8'd0;
  bit         force_blank = 1'b0;
  logic [7:0] r00_a, r00_b;
  logic       bz_a, bz_b;

  task automatic drive_pixel(input int x, input int y);
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    Red_in   = red_val;
    Green_in = 8'(x * 37 + y * 11 + 3);
    Blue_in  = 8'(255 - x * 29 - y * 5);
    blank    = !(force_blank || x == W - 1);
    @(negedge VGA_Clk);
    sb_check();
  endtask

  // One frame; State_in changes at pixel index chg_at and again at chg2_at.
  task automatic run_frame(input int chg_at, input logic [1:0] ns,
                           input int chg2_at, input logic [1:0] ns2);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int idx;
        idx = y * W + x;
        if (idx == chg_at)  State_in = ns;
        if (idx == chg2_at) State_in = ns2;
        drive_pixel(x, y);
        if (idx == 0) begin
          r00_a = red_a; r00_b = red_b; bz_a = busy_a; bz_b = busy_b;
        end
      end
    end
  endtask

  task automatic idle_frame();
    run_frame(-1, 2'd0, -1, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge VGA_Clk);
    check("reset_red_a", {24'd0, red_a}, 32'd0);
    check("reset_busy_a", {31'd0, busy_a}, 32'd0);
    check("reset_red_b", {24'd0, red_b}, 32'd0);
    Reset = 1'b0;

    // Pass-through after reset.
    red_val = 8'hC8;
    idle_frame();
    check("pass_red", {24'd0, r00_a}, 32'hC8);
    check("pass_busy", {31'd0, bz_a}, 32'd0);

    // Basic transition 0 -> 1 mid-frame.
    red_val = 8'd255;
    run_frame(10, 2'd1, -1, 2'd0);
    for (int f = 1; f <= EFF_A; f++) begin
      idle_frame();
      if (f == 1 || f == EFF_A) begin
        check("black_red", {24'd0, r00_a}, 32'd0);
        check("black_busy", {31'd0, bz_a}, 32'd1);
      end
    end
    idle_frame();
    check("fade_first", {24'd0, r00_a}, 32'd15);
    repeat (14) idle_frame();
    check("fade_240", {24'd0, r00_a}, 32'd239);
    check("fade_240_busy", {31'd0, bz_a}, 32'd1);
    idle_frame();
    check("fade_done_red", {24'd0, r00_a}, 32'd255);
    check("fade_done_busy", {31'd0, bz_a}, 32'd0);

    // Interrupt during fade at level 128.
    run_frame(7, 2'd0, -1, 2'd0);
    repeat (EFF_A) idle_frame();
    repeat (8) idle_frame();
    check("int_lvl128", {24'd0, r00_a}, 32'd127);
    run_frame(9, 2'd2, -1, 2'd0);
    idle_frame();
    check("int_black", {24'd0, r00_a}, 32'd0);
    check("int_busy", {31'd0, bz_a}, 32'd1);
    repeat (EFF_A - 1) idle_frame();
    idle_frame();
    check("int_refade", {24'd0, r00_a}, 32'd15);
    repeat (15) idle_frame();
    check("int_done_red", {24'd0, r00_a}, 32'd255);
    check("int_done_busy", {31'd0, bz_a}, 32'd0);

    // Blanking in IDLE.
    force_blank = 1'b1;
    idle_frame();
    check("blank_red", {24'd0, r00_a}, 32'd0);
    force_blank = 1'b0;
    idle_frame();
    check("unity_red", {24'd0, r00_a}, 32'd255);

    // Change on the frame-start cycle itself is acted on immediately.
    run_frame(0, 2'd3, -1, 2'd0);
    check("fs_chg_red", {24'd0, r00_a}, 32'd0);
    check("fs_chg_busy", {31'd0, bz_a}, 32'd1);
    repeat (EFF_A - 1 + 16) idle_frame();
    check("fs_chg_done", {31'd0, bz_a}, 32'd0);

    // Two changes in one frame collapse into one transition.
    run_frame(4, 2'd1, 12, 2'd3);
    idle_frame();
    check("collapse_black", {24'd0, r00_a}, 32'd0);
    repeat (EFF_A - 1) idle_frame();
    idle_frame();
    check("collapse_fade", {24'd0, r00_a}, 32'd15);
    repeat (15) idle_frame();
    check("collapse_done_red", {24'd0, r00_a}, 32'd255);
    check("collapse_done_busy", {31'd0, bz_a}, 32'd0);

    // Saturation on dut_b (STEP 100, HOLD 1): 0, 100, 200, 256.
    red_val = 8'd200;
    run_frame(6, 2'd1, -1, 2'd0);
    idle_frame();
    check("sat_0", {24'd0, r00_b}, 32'd0);
    check("sat_0_busy", {31'd0, bz_b}, 32'd1);
    idle_frame();
    check("sat_100", {24'd0, r00_b}, 32'd78);
    idle_frame();
    check("sat_200", {24'd0, r00_b}, 32'd156);
    idle_frame();
    check("sat_256", {24'd0, r00_b}, 32'd200);
    check("sat_idle", {31'd0, bz_b}, 32'd0);

    // Asynchronous reset while dut_a is still black / fading.
    drive_pixel(0, 0);
    drive_pixel(1, 0);
    drive_pixel(2, 0);
    check("pre_reset_busy", {31'd0, busy_a}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("async_red_a", {24'd0, red_a}, 32'd0);
    check("async_busy_a", {31'd0, busy_a}, 32'd0);
    check("async_red_b", {24'd0, red_b}, 32'd0);
    repeat (2) @(negedge VGA_Clk);
    Reset = 1'b0;
    idle_frame();
    check("post_reset_red", {24'd0, r00_a}, 32'd200);
    check("post_reset_busy", {31'd0, bz_a}, 32'd0);
    idle_frame();
    check("post_reset_busy2", {31'd0, bz_a}, 32'd0);
    check("post_reset_red_b", {24'd0, r00_b}, 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
